// File: rtl/uart_result_transmitter.sv
// UART 8N1 transmitter that formats a signed hundredths result as ASCII text ("-12.34\r\n")
// and shifts it out on TxD.
module uart_result_transmitter #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic        clk_fpga_100mhz,
    input  logic        reset,
    input  logic        send,
    input  logic        result_sign,
    input  logic [13:0] result_value,
    output logic        busy,
    output logic        done,
    output logic        TxD
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned VAL_W        = 14;
    localparam logic [VAL_W-1:0] VAL_MAX = VAL_W'(9999);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       char_buf [8];
    logic [3:0]       len;
    logic [3:0]       idx;
    logic [VAL_W-1:0] rem;
    logic [3:0]       digit;
    logic [1:0]       place;

    logic [VAL_W-1:0] weight_c;
    logic             bit_end_c;
    logic [7:0]       digit_chr_c;
    logic [7:0]       ones_chr_c;
    logic [2:0]       wr_ptr_c;
    logic [VAL_W-1:0] sat_value_c;

    // Place weight for the digit currently being extracted: thousands, hundreds, tens.
    always_comb begin
        weight_c = VAL_W'(10);
        case (place)
            2'd0:    weight_c = VAL_W'(1000);
            2'd1:    weight_c = VAL_W'(100);
            default: weight_c = VAL_W'(10);
        endcase
    end

    assign bit_end_c   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign digit_chr_c = 8'h30 + {4'h0, digit};
    assign ones_chr_c  = 8'h30 + {4'h0, rem[3:0]};
    assign wr_ptr_c    = len[2:0];
    assign sat_value_c = (result_value > VAL_MAX) ? VAL_MAX : result_value;

    always_ff @(posedge clk_fpga_100mhz) begin
        if (reset) begin
            state   <= S_IDLE;
            TxD     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            len     <= '0;
            idx     <= '0;
            rem     <= '0;
            digit   <= '0;
            place   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A send coinciding with the done pulse is deliberately dropped.
                    if (send && !busy && !done) begin
                        busy  <= 1'b1;
                        rem   <= sat_value_c;
                        place <= 2'd0;
                        digit <= 4'd0;
                        idx   <= 4'd0;
                        state <= S_CONVERT;
                        if (result_sign && (result_value != '0)) begin
                            char_buf[0] <= 8'h2D;
                            len         <= 4'd1;
                        end else begin
                            len <= 4'd0;
                        end
                    end
                end

                S_CONVERT: begin
                    if (rem >= weight_c) begin
                        rem   <= rem - weight_c;
                        digit <= digit + 4'd1;
                    end else begin
                        digit <= 4'd0;
                        place <= place + 2'd1;
                        case (place)
                            2'd0: begin
                                if (digit != 4'd0) begin
                                    char_buf[wr_ptr_c] <= digit_chr_c;
                                    len                <= len + 4'd1;
                                end
                            end
                            2'd1: begin
                                char_buf[wr_ptr_c]        <= digit_chr_c;
                                char_buf[wr_ptr_c + 3'd1] <= 8'h2E;
                                len                       <= len + 4'd2;
                            end
                            default: begin
                                // Tens loop leaves the ones digit in rem; finish the buffer in one go.
                                char_buf[wr_ptr_c]        <= digit_chr_c;
                                char_buf[wr_ptr_c + 3'd1] <= ones_chr_c;
                                char_buf[wr_ptr_c + 3'd2] <= 8'h0D;
                                char_buf[wr_ptr_c + 3'd3] <= 8'h0A;
                                len                       <= len + 4'd4;
                                shreg                     <= char_buf[0];
                                clk_cnt                   <= '0;
                                TxD                       <= 1'b0;
                                state                     <= S_START;
                            end
                        endcase
                    end
                end

                S_START: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        TxD     <= shreg[0];
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            TxD   <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TxD     <= shreg[1];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        if ((idx + 4'd1) < len) begin
                            idx   <= idx + 4'd1;
                            shreg <= char_buf[3'(idx + 4'd1)];
                            TxD   <= 1'b0;
                            state <= S_START;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_transmitter.sv
// Directed bench for uart_result_transmitter: decodes TxD as a UART receiver and checks
// the ASCII message, bit timing, busy/done behaviour, ignored sends and mid-frame reset.
module tb_uart_result_transmitter;

    localparam int unsigned CPB = 10;

    logic        clk_fpga_100mhz = 1'b0;
    logic        reset;
    logic        send;
    logic        result_sign;
    logic [13:0] result_value;
    logic        busy;
    logic        done;
    logic        TxD;

    int cyc      = 0;
    int done_cnt = 0;
    int n_assert = 0;
    int n_fail   = 0;

    uart_result_transmitter #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk_fpga_100mhz(clk_fpga_100mhz),
        .reset          (reset),
        .send           (send),
        .result_sign    (result_sign),
        .result_value   (result_value),
        .busy           (busy),
        .done           (done),
        .TxD            (TxD)
    );

    always #5 clk_fpga_100mhz = ~clk_fpga_100mhz;

    always @(posedge clk_fpga_100mhz) cyc <= cyc + 1;
    always @(negedge clk_fpga_100mhz) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one result and receive/check the whole message; optionally re-pulse send mid-message.
    task automatic run_msg(input string tag, input logic sgn, input logic [13:0] val,
                           input logic [63:0] msg, input int len, input bit resend);
        int         n_acc;
        int         e0;
        int         e_prev;
        int         e;
        int         tmo;
        int         dc0;
        logic [7:0] b;
        dc0 = done_cnt;
        @(negedge clk_fpga_100mhz);
        result_sign  = sgn;
        result_value = val;
        send         = 1'b1;
        @(negedge clk_fpga_100mhz);
        send  = 1'b0;
        n_acc = cyc;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        if (resend) begin
            fork
                begin
                    repeat (50) @(negedge clk_fpga_100mhz);
                    send = 1'b1;
                    @(negedge clk_fpga_100mhz);
                    send = 1'b0;
                end
            join_none
        end
        e0     = 0;
        e_prev = 0;
        for (int i = 0; i < len; i++) begin
            tmo = 0;
            while (TxD !== 1'b0 && tmo < 200) begin
                @(negedge clk_fpga_100mhz);
                tmo++;
            end
            check({tag, " start_found"}, 32'(tmo < 200), 32'd1);
            if (tmo >= 200) return;
            e = cyc;
            if (i == 0) begin
                e0 = e;
                check({tag, " start_latency_ok"}, 32'((e - n_acc) > 0 && (e - n_acc) <= 32), 32'd1);
            end else begin
                check({tag, " char_spacing"}, 32'(e - e_prev), 32'(10 * CPB));
            end
            e_prev = e;
            repeat (CPB / 2) @(negedge clk_fpga_100mhz);
            check({tag, " start_bit"}, 32'(TxD), 32'd0);
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) @(negedge clk_fpga_100mhz);
                b[j] = TxD;
            end
            repeat (CPB) @(negedge clk_fpga_100mhz);
            check({tag, " stop_bit"}, 32'(TxD), 32'd1);
            check($sformatf("%s byte%0d", tag, i), 32'(b), 32'(msg[8 * (len - 1 - i) +: 8]));
        end
        tmo = 0;
        while (done !== 1'b1 && tmo < 40) begin
            @(negedge clk_fpga_100mhz);
            tmo++;
        end
        check({tag, " done_seen"}, 32'(tmo < 40), 32'd1);
        check({tag, " done_time"}, 32'(cyc - e0), 32'(10 * CPB * len));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        // send on the done cycle must be ignored
        send = 1'b1;
        @(negedge clk_fpga_100mhz);
        send = 1'b0;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk_fpga_100mhz);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_txd"}, 32'(TxD), 32'd1);
        check({tag, " done_count"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        int tmo;
        reset        = 1'b1;
        send         = 1'b0;
        result_sign  = 1'b0;
        result_value = '0;
        repeat (3) @(negedge clk_fpga_100mhz);
        check("reset_txd", 32'(TxD), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_fpga_100mhz);

        run_msg("v314",    1'b0, 14'd314,   64'h332E31340D0A,     6, 1'b0);
        run_msg("neg50",   1'b1, 14'd50,    64'h2D302E35300D0A,   7, 1'b0);
        run_msg("neg0",    1'b1, 14'd0,     64'h302E30300D0A,     6, 1'b0);
        run_msg("sat",     1'b0, 14'd12000, 64'h39392E39390D0A,   7, 1'b0);
        run_msg("v100",    1'b0, 14'd100,   64'h312E30300D0A,     6, 1'b0);
        run_msg("resend",  1'b0, 14'd314,   64'h332E31340D0A,     6, 1'b1);
        run_msg("neg9999", 1'b1, 14'd9999,  64'h2D39392E39390D0A, 8, 1'b0);
        run_msg("v7",      1'b0, 14'd7,     64'h302E30370D0A,     6, 1'b0);

        // Reset in the middle of the second character's data bits
        @(negedge clk_fpga_100mhz);
        result_sign  = 1'b0;
        result_value = 14'd314;
        send         = 1'b1;
        @(negedge clk_fpga_100mhz);
        send = 1'b0;
        tmo  = 0;
        while (TxD !== 1'b0 && tmo < 200) begin
            @(negedge clk_fpga_100mhz);
            tmo++;
        end
        check("rst_start_found", 32'(tmo < 200), 32'd1);
        repeat (10 * CPB + 3 * CPB) @(negedge clk_fpga_100mhz);
        check("rst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk_fpga_100mhz);
        check("rst_txd", 32'(TxD), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_fpga_100mhz);
        run_msg("after_rst", 1'b0, 14'd314, 64'h332E31340D0A, 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
